// File: rtl/cmplx_rounding_arb.sv
// cmplx_rounding_arb
//
// Packet-level round-robin arbiter that shares one external complex rounding
// unit between pN framed sample streams. One requester is granted per burst
// (sop..eop). Its samples are registered onto the rounding unit's input. The
// burst framing and the source tag travel through a delay line whose length
// matches the unit's latency, so rounded samples leave re-framed and labelled.
//
// Ports:
//   iclk, ireset, iclkena        clock, async active-high reset, clock enable
//   ireq_val/sop/eop [pN]        per-requester framing
//   ireq_re/im [pN*pIDAT_W]      per-requester samples, k at [k*pIDAT_W +: pIDAT_W]
//   oreq_rdy [pN]                per-requester ready, one-hot or zero
//   orval, ordat_re/im           registered feed into the rounding unit
//   irval, irdat_re/im           rounded samples back from the unit
//   oval, osop, oeop, otag       re-framed output, tagged with the source index
//   odat_re/im                   rounded output samples
//   oerr                         one-cycle pulse on a stray sop inside a burst
module cmplx_rounding_arb #(
    parameter int pN      = 4,
    parameter int pIDAT_W = 24,
    parameter int pODAT_W = 8,
    parameter int pLAT    = 1,
    parameter int pTAG_W  = $clog2(pN)
) (
    input  logic                   iclk,
    input  logic                   ireset,
    input  logic                   iclkena,
    input  logic [pN-1:0]          ireq_val,
    input  logic [pN-1:0]          ireq_sop,
    input  logic [pN-1:0]          ireq_eop,
    input  logic [pN*pIDAT_W-1:0]  ireq_re,
    input  logic [pN*pIDAT_W-1:0]  ireq_im,
    output logic [pN-1:0]          oreq_rdy,
    output logic                   orval,
    output logic [pIDAT_W-1:0]     ordat_re,
    output logic [pIDAT_W-1:0]     ordat_im,
    input  logic                   irval,
    input  logic [pODAT_W-1:0]     irdat_re,
    input  logic [pODAT_W-1:0]     irdat_im,
    output logic                   oval,
    output logic                   osop,
    output logic                   oeop,
    output logic [pTAG_W-1:0]      otag,
    output logic [pODAT_W-1:0]     odat_re,
    output logic [pODAT_W-1:0]     odat_im,
    output logic                   oerr
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    localparam int SIDE_W = pTAG_W + 2;

    logic [0:0]        state;
    logic [pTAG_W-1:0] grant;
    logic [pTAG_W-1:0] last_grant;
    logic              first_word;

    logic [pN-1:0]     qual;
    logic [pTAG_W-1:0] pick;
    logic              pick_found;
    int                sel_idx;

    logic              xfer;
    logic              xfer_sop;
    logic              xfer_eop;

    // side_q[0] is loaded together with orval; side_q[1..pLAT] mirror the
    // rounding unit's own pipeline so side_q[pLAT] lines up with irval.
    logic [SIDE_W-1:0] side_q [0:pLAT];

    // Only the start of a burst can win arbitration.
    assign qual = ireq_val & ireq_sop;

    // Round-robin search starting just above the last served requester.
    // The modulo keeps the search correct for non-power-of-two pN.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        sel_idx    = 0;
        for (int i = 1; i <= pN; i++) begin
            sel_idx = (int'(last_grant) + i) % pN;
            if (!pick_found && qual[sel_idx]) begin
                pick_found = 1'b1;
                pick       = sel_idx[pTAG_W-1:0];
            end
        end
    end

    // Ready is only offered to the granted requester, and only on enabled
    // cycles, so a disabled cycle can never complete a transfer.
    always_comb begin
        oreq_rdy = '0;
        if (state == S_BURST && iclkena) begin
            oreq_rdy[grant] = 1'b1;
        end
    end

    assign xfer     = ireq_val[grant] & oreq_rdy[grant];
    assign xfer_sop = ireq_sop[grant];
    assign xfer_eop = ireq_eop[grant];

    // Arbitration FSM. Each burst costs one IDLE cycle for the grant decision;
    // the grant is held across val gaps until the eop word is accepted.
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            state      <= S_IDLE;
            grant      <= '0;
            last_grant <= pTAG_W'(pN - 1);
            first_word <= 1'b0;
        end else if (iclkena) begin
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        grant      <= pick;
                        state      <= S_BURST;
                        first_word <= 1'b1;
                    end
                end
                S_BURST: begin
                    if (xfer) begin
                        first_word <= 1'b0;
                        if (xfer_eop) begin
                            state      <= S_IDLE;
                            last_grant <= grant;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Stray sop after the first word. Updated every cycle so the flag is a
    // single-cycle pulse even if the enable drops right after it.
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            oerr <= 1'b0;
        end else begin
            oerr <= xfer & xfer_sop & ~first_word;
        end
    end

    // Feed register into the rounding unit; data holds between transfers.
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            orval    <= 1'b0;
            ordat_re <= '0;
            ordat_im <= '0;
        end else if (iclkena) begin
            orval <= xfer;
            if (xfer) begin
                ordat_re <= ireq_re[int'(grant)*pIDAT_W +: pIDAT_W];
                ordat_im <= ireq_im[int'(grant)*pIDAT_W +: pIDAT_W];
            end
        end
    end

    // Tag/framing delay line. Empty slots carry zeros so a reset flushes any
    // in-flight labels while the unit may still return data.
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            for (int i = 0; i <= pLAT; i++) begin
                side_q[i] <= '0;
            end
        end else if (iclkena) begin
            side_q[0] <= xfer ? {grant, xfer_sop, xfer_eop} : '0;
            for (int i = 1; i <= pLAT; i++) begin
                side_q[i] <= side_q[i-1];
            end
        end
    end

    assign oval    = irval;
    assign odat_re = irdat_re;
    assign odat_im = irdat_im;

    assign {otag, osop, oeop} = irval ? side_q[pLAT] : '0;

endmodule

// File: tb/tb_cmplx_rounding_arb.sv
// tb_cmplx_rounding_arb
//
// Directed bench for cmplx_rounding_arb with pN=4 and pLAT=3. A small
// rounding-unit stub (keep the top 8 bits of each component, pLAT enabled
// stages) closes the loop. Requesters are per-port word queues; the expected
// output stream is hand-written per scenario into a scoreboard that a
// separate monitor drains whenever the DUT presents oval.
module tb_cmplx_rounding_arb;

    localparam int N   = 4;
    localparam int IW  = 24;
    localparam int OW  = 8;
    localparam int LAT = 3;
    localparam int TW  = 2;

    logic              iclk;
    logic              ireset;
    logic              iclkena;
    logic [N-1:0]      ireq_val;
    logic [N-1:0]      ireq_sop;
    logic [N-1:0]      ireq_eop;
    logic [N*IW-1:0]   ireq_re;
    logic [N*IW-1:0]   ireq_im;
    logic [N-1:0]      oreq_rdy;
    logic              orval;
    logic [IW-1:0]     ordat_re;
    logic [IW-1:0]     ordat_im;
    logic              irval;
    logic [OW-1:0]     irdat_re;
    logic [OW-1:0]     irdat_im;
    logic              oval;
    logic              osop;
    logic              oeop;
    logic [TW-1:0]     otag;
    logic [OW-1:0]     odat_re;
    logic [OW-1:0]     odat_im;
    logic              oerr;

    typedef struct {
        bit            val;
        bit            sop;
        bit            eop;
        logic [IW-1:0] re;
        logic [IW-1:0] im;
    } word_t;

    typedef struct {
        int            tag;
        bit            sop;
        bit            eop;
        logic [OW-1:0] re;
        logic [OW-1:0] im;
        int            cyc;
    } exp_t;

    word_t rq [N][$];
    exp_t  sb [$];

    int errors     = 0;
    int checks     = 0;
    int ecyc       = 0;
    int base       = 0;
    bit mark_base  = 0;
    int err_pulses = 0;
    logic unit_rst;

    logic [2*OW:0] unit_q [1:LAT];

    cmplx_rounding_arb #(
        .pN(N), .pIDAT_W(IW), .pODAT_W(OW), .pLAT(LAT)
    ) dut (
        .iclk(iclk), .ireset(ireset), .iclkena(iclkena),
        .ireq_val(ireq_val), .ireq_sop(ireq_sop), .ireq_eop(ireq_eop),
        .ireq_re(ireq_re), .ireq_im(ireq_im), .oreq_rdy(oreq_rdy),
        .orval(orval), .ordat_re(ordat_re), .ordat_im(ordat_im),
        .irval(irval), .irdat_re(irdat_re), .irdat_im(irdat_im),
        .oval(oval), .osop(osop), .oeop(oeop), .otag(otag),
        .odat_re(odat_re), .odat_im(odat_im), .oerr(oerr)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    // Enabled-cycle counter used as the latency time base.
    always @(posedge iclk) begin
        if (iclkena) ecyc <= ecyc + 1;
    end

    // Rounding-unit stub: top OW bits per component, LAT enabled stages.
    // Not tied to ireset so in-flight samples survive a DUT reset.
    always @(posedge iclk or posedge unit_rst) begin
        if (unit_rst) begin
            for (int i = 1; i <= LAT; i++) unit_q[i] <= '0;
        end else if (iclkena) begin
            unit_q[1] <= {orval, ordat_re[IW-1:IW-OW], ordat_im[IW-1:IW-OW]};
            for (int i = 2; i <= LAT; i++) unit_q[i] <= unit_q[i-1];
        end
    end

    assign irval    = unit_q[LAT][2*OW];
    assign irdat_re = unit_q[LAT][2*OW-1:OW];
    assign irdat_im = unit_q[LAT][OW-1:0];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic addWord(input int k, input bit v, input bit s, input bit e,
                           input logic [IW-1:0] re, input logic [IW-1:0] im);
        word_t w;
        w.val = v; w.sop = s; w.eop = e; w.re = re; w.im = im;
        rq[k].push_back(w);
    endtask

    task automatic addExp(input int tag, input bit s, input bit e,
                          input logic [OW-1:0] re, input logic [OW-1:0] im, input int cyc);
        exp_t x;
        x.tag = tag; x.sop = s; x.eop = e; x.re = re; x.im = im; x.cyc = cyc;
        sb.push_back(x);
    endtask

    function automatic int pendingCount();
        int n = sb.size();
        for (int k = 0; k < N; k++) n += rq[k].size();
        return n;
    endfunction

    // One clock cycle of requester behaviour: present queue heads at the
    // falling edge, then retire the head of any port that will transfer.
    task automatic stepCycle(input bit en, input bit rst_pulse, input bit chk_rdy,
                             input logic [N-1:0] exp_rdy);
        word_t w;
        @(negedge iclk);
        ireset = 1'b0;
        if (mark_base) begin
            base      = ecyc;
            mark_base = 1'b0;
        end
        iclkena  = en;
        ireq_val = '0;
        ireq_sop = '0;
        ireq_eop = '0;
        ireq_re  = '0;
        ireq_im  = '0;
        for (int k = 0; k < N; k++) begin
            if (rq[k].size() > 0) begin
                w = rq[k][0];
                ireq_val[k]          = w.val;
                ireq_sop[k]          = w.sop;
                ireq_eop[k]          = w.eop;
                ireq_re[k*IW +: IW]  = w.re;
                ireq_im[k*IW +: IW]  = w.im;
            end
        end
        if (rst_pulse) begin
            ireset = 1'b1;
            #1;
            checkOutput("rdy_in_reset", 32'(oreq_rdy), 0);
            checkOutput("orval_in_reset", 32'(orval), 0);
        end else begin
            #1;
            if (!en) checkOutput("rdy_when_disabled", 32'(oreq_rdy), 0);
            if (chk_rdy) checkOutput("rdy_pattern", 32'(oreq_rdy), 32'(exp_rdy));
            for (int k = 0; k < N; k++) begin
                if (rq[k].size() > 0) begin
                    w = rq[k][0];
                    if (w.val) begin
                        if (oreq_rdy[k]) void'(rq[k].pop_front());
                    end else if (en) begin
                        void'(rq[k].pop_front());
                    end
                end
            end
        end
    endtask

    // Tables read left to right: enable bit per cycle, ready nibble per cycle.
    task automatic runTable(input int n, input logic [15:0] enm, input logic [63:0] tab);
        for (int c = 0; c < n; c++) begin
            stepCycle(enm[15-c], 1'b0, 1'b1, tab[63-4*c -: 4]);
        end
    endtask

    task automatic doReset();
        @(negedge iclk);
        ireset   = 1'b1;
        iclkena  = 1'b1;
        ireq_val = '0;
        ireq_sop = '0;
        ireq_eop = '0;
        @(negedge iclk);
        ireset = 1'b0;
    endtask

    task automatic finishScenario(input int exp_err);
        int n = 0;
        while (pendingCount() > 0 && n < 80) begin
            stepCycle(1'b1, 1'b0, 1'b0, '0);
            n++;
        end
        repeat (6) stepCycle(1'b1, 1'b0, 1'b0, '0);
        checkOutput("drain_pending", 32'(pendingCount()), 0);
        checkOutput("oerr_pulses", 32'(err_pulses), 32'(exp_err));
    endtask

    // Load requester queues and the expected output stream for one scenario.
    // Expected cycles are enabled cycles from the scenario's first cycle.
    task automatic applyStimulus(input int sc);
        err_pulses = 0;
        mark_base  = 1'b1;
        $display("[TB] scenario %0d", sc);
        case (sc)
            1: begin
                addWord(2, 1, 1, 0, 24'h01_0100, 24'hF1_0001);
                addWord(2, 1, 0, 0, 24'h02_0200, 24'hF2_0002);
                addWord(2, 1, 0, 0, 24'h03_0300, 24'hF3_0003);
                addWord(2, 1, 0, 1, 24'h04_0400, 24'hF4_0004);
                addExp(2, 1, 0, 8'h01, 8'hF1, 5);
                addExp(2, 0, 0, 8'h02, 8'hF2, 6);
                addExp(2, 0, 0, 8'h03, 8'hF3, 7);
                addExp(2, 0, 1, 8'h04, 8'hF4, 8);
            end
            2: begin
                addWord(0, 1, 1, 0, 24'h20_0000, 24'h60_0000);
                addWord(0, 1, 0, 1, 24'h21_0000, 24'h61_0000);
                addWord(0, 1, 1, 0, 24'h22_0000, 24'h62_0000);
                addWord(0, 1, 0, 1, 24'h23_0000, 24'h63_0000);
                addWord(1, 1, 1, 0, 24'h30_0000, 24'h70_0000);
                addWord(1, 1, 0, 1, 24'h31_0000, 24'h71_0000);
                addWord(2, 1, 1, 0, 24'h40_0000, 24'h80_0000);
                addWord(2, 1, 0, 1, 24'h41_0000, 24'h81_0000);
                addWord(3, 1, 1, 0, 24'h50_0000, 24'h90_0000);
                addWord(3, 1, 0, 1, 24'h51_0000, 24'h91_0000);
                addExp(0, 1, 0, 8'h20, 8'h60, 5);
                addExp(0, 0, 1, 8'h21, 8'h61, 6);
                addExp(1, 1, 0, 8'h30, 8'h70, 8);
                addExp(1, 0, 1, 8'h31, 8'h71, 9);
                addExp(2, 1, 0, 8'h40, 8'h80, 11);
                addExp(2, 0, 1, 8'h41, 8'h81, 12);
                addExp(3, 1, 0, 8'h50, 8'h90, 14);
                addExp(3, 0, 1, 8'h51, 8'h91, 15);
                addExp(0, 1, 0, 8'h22, 8'h62, 17);
                addExp(0, 0, 1, 8'h23, 8'h63, 18);
            end
            3: begin
                addWord(1, 1, 1, 0, 24'h0A_0000, 24'h1A_0000);
                addWord(1, 0, 0, 0, 24'h00_0000, 24'h00_0000);
                addWord(1, 0, 0, 0, 24'h00_0000, 24'h00_0000);
                addWord(1, 1, 0, 0, 24'h0B_0000, 24'h1B_0000);
                addWord(1, 1, 0, 1, 24'h0C_0000, 24'h1C_0000);
                addWord(0, 1, 1, 0, 24'h0D_0000, 24'h1D_0000);
                addWord(0, 1, 0, 1, 24'h0E_0000, 24'h1E_0000);
                addExp(1, 1, 0, 8'h0A, 8'h1A, 5);
                addExp(1, 0, 0, 8'h0B, 8'h1B, 8);
                addExp(1, 0, 1, 8'h0C, 8'h1C, 9);
                addExp(0, 1, 0, 8'h0D, 8'h1D, 11);
                addExp(0, 0, 1, 8'h0E, 8'h1E, 12);
            end
            4: begin
                addWord(3, 1, 1, 0, 24'h33_0000, 24'h43_0000);
                addWord(3, 1, 0, 0, 24'h34_0000, 24'h44_0000);
                addWord(3, 1, 0, 1, 24'h35_0000, 24'h45_0000);
                addExp(3, 1, 0, 8'h33, 8'h43, 5);
                addExp(3, 0, 0, 8'h34, 8'h44, 6);
                addExp(3, 0, 1, 8'h35, 8'h45, 7);
            end
            5: begin
                addWord(0, 1, 1, 0, 24'h51_0000, 24'hA1_0000);
                addWord(0, 1, 0, 0, 24'h52_0000, 24'hA2_0000);
                addWord(0, 1, 1, 0, 24'h53_0000, 24'hA3_0000);
                addWord(0, 1, 0, 0, 24'h54_0000, 24'hA4_0000);
                addWord(0, 1, 0, 1, 24'h55_0000, 24'hA5_0000);
                addExp(0, 1, 0, 8'h51, 8'hA1, 5);
                addExp(0, 0, 0, 8'h52, 8'hA2, 6);
                addExp(0, 1, 0, 8'h53, 8'hA3, 7);
                addExp(0, 0, 0, 8'h54, 8'hA4, 8);
                addExp(0, 0, 1, 8'h55, 8'hA5, 9);
            end
            6: begin
                addWord(1, 1, 1, 1, 24'h61_0000, 24'hB1_0000);
                addWord(1, 1, 1, 1, 24'h62_0000, 24'hB2_0000);
                addWord(2, 1, 1, 1, 24'h63_0000, 24'hB3_0000);
                addExp(1, 1, 1, 8'h61, 8'hB1, 5);
                addExp(2, 1, 1, 8'h63, 8'hB3, 7);
                addExp(1, 1, 1, 8'h62, 8'hB2, 9);
            end
            default: begin
                addWord(2, 1, 1, 0, 24'h71_0000, 24'hC1_0000);
                addWord(2, 1, 0, 0, 24'h72_0000, 24'hC2_0000);
                addWord(2, 1, 0, 0, 24'h73_0000, 24'hC3_0000);
                addWord(2, 1, 0, 1, 24'h74_0000, 24'hC4_0000);
                addExp(0, 0, 0, 8'h71, 8'hC1, 5);
                addExp(0, 1, 1, 8'h75, 8'hC5, 9);
                addExp(3, 1, 1, 8'h76, 8'hC6, 11);
            end
        endcase
    endtask

    // Monitor: pops the scoreboard on every enabled cycle that shows oval.
    initial begin
        exp_t x;
        forever begin
            @(negedge iclk);
            #2;
            if (oerr === 1'b1) err_pulses++;
            if (oval === 1'b1 && iclkena === 1'b1) begin
                checkOutput("oval_expected", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    x = sb.pop_front();
                    checkOutput("otag", 32'(otag), 32'(x.tag));
                    checkOutput("osop", 32'(osop), 32'(x.sop));
                    checkOutput("oeop", 32'(oeop), 32'(x.eop));
                    checkOutput("odat_re", 32'(odat_re), 32'(x.re));
                    checkOutput("odat_im", 32'(odat_im), 32'(x.im));
                    checkOutput("latency", 32'(ecyc - base), 32'(x.cyc));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        unit_rst = 1'b1;
        ireset   = 1'b1;
        iclkena  = 1'b0;
        ireq_val = '0;
        ireq_sop = '0;
        ireq_eop = '0;
        ireq_re  = '0;
        ireq_im  = '0;
        @(negedge iclk);
        #1;
        checkOutput("reset_rdy", 32'(oreq_rdy), 0);
        checkOutput("reset_orval", 32'(orval), 0);
        checkOutput("reset_oerr", 32'(oerr), 0);
        checkOutput("reset_ordat_re", 32'(ordat_re), 0);
        checkOutput("reset_otag", 32'(otag), 0);
        @(negedge iclk);
        unit_rst = 1'b0;
        ireset   = 1'b0;

        doReset();
        applyStimulus(1);
        runTable(6, 16'hFFFF, 64'h0444_4000_0000_0000);
        finishScenario(0);

        doReset();
        applyStimulus(2);
        runTable(16, 16'hFFFF, 64'h0110_2204_4088_0110);
        finishScenario(0);

        applyStimulus(3);
        runTable(9, 16'hFFFF, 64'h0222_2201_1000_0000);
        finishScenario(0);

        applyStimulus(4);
        runTable(6, 16'hD400, 64'h0808_0800_0000_0000);
        finishScenario(0);

        applyStimulus(5);
        runTable(7, 16'hFFFF, 64'h0111_1100_0000_0000);
        finishScenario(1);

        applyStimulus(6);
        runTable(7, 16'hFFFF, 64'h0204_0200_0000_0000);
        finishScenario(0);

        applyStimulus(7);
        runTable(3, 16'hFFFF, 64'h0440_0000_0000_0000);
        stepCycle(1'b1, 1'b1, 1'b0, '0);
        rq[2].delete();
        addWord(0, 1, 1, 1, 24'h75_0000, 24'hC5_0000);
        addWord(3, 1, 1, 1, 24'h76_0000, 24'hC6_0000);
        runTable(5, 16'hFFFF, 64'h0108_0000_0000_0000);
        finishScenario(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
